rb_param: RTL

- Parametrised successor to the 16x32 register bank.
- Provides configurable width and depth, 2 synchronous read ports and 1 write port.
- Adds write-to-read bypass, an optional hard-wired zero register, full reset of every entry, a per-register busy scoreboard for hazard detection, and a selectable debug tap.
- Sits between the decode stage (rs/rt/reserve) and the writeback stage (rd/in1) of the MIPS32 datapath.

---
 rtl/rb_param_if.sv | 33 +++
 rtl/rb_param.sv | 111 +++++++++++
 2 files changed

// File: rtl/rb_param_if.sv
// Decode/writeback-facing bundle for rb_param: read, write, reserve, busy and debug signals.
// The master drives indices, strobes and write data; the slave returns read data, busy flags and the debug tap.
interface rb_param_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int DBG_W  = 16
);
  logic              enable;
  logic              read;
  logic [ADDR_W-1:0] rs;
  logic [ADDR_W-1:0] rt;
  logic [DATA_W-1:0] out1;
  logic [DATA_W-1:0] out2;
  logic              write;
  logic [ADDR_W-1:0] rd;
  logic [DATA_W-1:0] in1;
  logic              reserve;
  logic [ADDR_W-1:0] reserve_idx;
  logic              rs_busy;
  logic              rt_busy;
  logic [ADDR_W-1:0] dbg_sel;
  logic [DBG_W-1:0]  dbg_out;

  modport master (
    output enable, read, rs, rt, write, rd, in1, reserve, reserve_idx, dbg_sel,
    input  out1, out2, rs_busy, rt_busy, dbg_out
  );

  modport slave (
    input  enable, read, rs, rt, write, rd, in1, reserve, reserve_idx, dbg_sel,
    output out1, out2, rs_busy, rt_busy, dbg_out
  );
endinterface

// File: rtl/rb_param.sv
// Parametrised register bank: 2 read ports, 1 write port, write bypass, optional zero register, busy scoreboard, debug tap.
// Read data is registered (1 cycle); busy flags and debug tap are combinational; no backpressure, every fired request is taken.
module rb_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 4,
  parameter int ZERO_REG = 1,
  parameter int DBG_W    = 16
) (
  input  logic        clk,
  input  logic        reset_all,
  rb_param_if.slave   bus
);
  localparam int DEPTH    = 1 << ADDR_W;
  localparam bit HAS_ZERO = (ZERO_REG != 0);

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;
  logic [DATA_W-1:0] out1_q;
  logic [DATA_W-1:0] out1_d;
  logic [DATA_W-1:0] out2_q;
  logic [DATA_W-1:0] out2_d;

  logic wr_fire;
  logic rd_fire;
  logic rsv_fire;
  logic wr_eff;
  logic rsv_eff;

  // Read source: hard zero, then same-cycle write data, then stored value.
  function automatic logic [DATA_W-1:0] src_sel(
    input logic [ADDR_W-1:0] idx,
    input logic [DATA_W-1:0] stored,
    input logic              byp_en,
    input logic [ADDR_W-1:0] wr_idx,
    input logic [DATA_W-1:0] wr_dat
  );
    logic [DATA_W-1:0] res;
    res = stored;
    if (byp_en && (wr_idx == idx)) begin
      res = wr_dat;
    end
    if (HAS_ZERO && (idx == '0)) begin
      res = '0;
    end
    return res;
  endfunction

  always_comb begin
    wr_fire  = bus.write & bus.enable;
    rd_fire  = bus.read & bus.enable;
    rsv_fire = bus.reserve & bus.enable;
    wr_eff   = wr_fire & ~(HAS_ZERO & (bus.rd == '0));
    rsv_eff  = rsv_fire & ~(HAS_ZERO & (bus.reserve_idx == '0));
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (wr_eff) begin
      regs_d[bus.rd] = bus.in1;
    end
  end

  // Clear first so a reserve to the same index wins over the completing write.
  always_comb begin
    busy_d = busy_q;
    if (wr_fire) begin
      busy_d[bus.rd] = 1'b0;
    end
    if (rsv_eff) begin
      busy_d[bus.reserve_idx] = 1'b1;
    end
  end

  always_comb begin
    out1_d = out1_q;
    out2_d = out2_q;
    if (rd_fire) begin
      out1_d = src_sel(bus.rs, regs_q[bus.rs], wr_eff, bus.rd, bus.in1);
      out2_d = src_sel(bus.rt, regs_q[bus.rt], wr_eff, bus.rd, bus.in1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset_all) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      busy_q <= '0;
      out1_q <= '0;
      out2_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= regs_d[i];
      end
      busy_q <= busy_d;
      out1_q <= out1_d;
      out2_q <= out2_d;
    end
  end

  assign bus.out1    = out1_q;
  assign bus.out2    = out2_q;
  // A completing write hides the hazard in the same cycle, matching the data bypass.
  assign bus.rs_busy = busy_q[bus.rs] & ~(wr_eff & (bus.rd == bus.rs));
  assign bus.rt_busy = busy_q[bus.rt] & ~(wr_eff & (bus.rd == bus.rt));
  assign bus.dbg_out = regs_q[bus.dbg_sel][DBG_W-1:0];
endmodule
